// File: rtl/myriadrf_wb_arbiter.sv
// rtl/myriadrf_wb_arbiter.sv - two-requester Wishbone B3 round-robin arbiter (TX/RX DMA to memory)
// Optional stall watchdog enabled by defining MYRIADRF_ARB_TIMEOUT_EN.
module myriadrf_wb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic [31:0] wbs_tx_adr_i,
  input  logic [31:0] wbs_tx_dat_i,
  input  logic [3:0]  wbs_tx_sel_i,
  input  logic        wbs_tx_we_i,
  input  logic        wbs_tx_cyc_i,
  input  logic        wbs_tx_stb_i,
  input  logic [2:0]  wbs_tx_cti_i,
  input  logic [1:0]  wbs_tx_bte_i,
  output logic [31:0] wbs_tx_dat_o,
  output logic        wbs_tx_ack_o,
  output logic        wbs_tx_err_o,
  output logic        wbs_tx_rty_o,
  input  logic [31:0] wbs_rx_adr_i,
  input  logic [31:0] wbs_rx_dat_i,
  input  logic [3:0]  wbs_rx_sel_i,
  input  logic        wbs_rx_we_i,
  input  logic        wbs_rx_cyc_i,
  input  logic        wbs_rx_stb_i,
  input  logic [2:0]  wbs_rx_cti_i,
  input  logic [1:0]  wbs_rx_bte_i,
  output logic [31:0] wbs_rx_dat_o,
  output logic        wbs_rx_ack_o,
  output logic        wbs_rx_err_o,
  output logic        wbs_rx_rty_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GNT_TX = 2'b01,
    GNT_RX = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic   last_rx, last_rx_nxt;
  logic   sel_tx, sel_rx;
  logic   cyc_mux, stb_mux, resp, timeout_hit;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state   <= IDLE;
      last_rx <= 1'b1;
    end else begin
      state   <= state_nxt;
      last_rx <= last_rx_nxt;
    end
  end

  // Only registered state and live cyc_i feed arbitration; slave responses never do.
  always_comb begin
    state_nxt   = state;
    last_rx_nxt = last_rx;
    case (state)
      IDLE: begin
        if (wbs_tx_cyc_i && wbs_rx_cyc_i) state_nxt = last_rx ? GNT_TX : GNT_RX;
        else if (wbs_tx_cyc_i)            state_nxt = GNT_TX;
        else if (wbs_rx_cyc_i)            state_nxt = GNT_RX;
      end
      GNT_TX: begin
        if (!wbs_tx_cyc_i) begin
          last_rx_nxt = 1'b0;
          state_nxt   = wbs_rx_cyc_i ? GNT_RX : IDLE;
        end
      end
      GNT_RX: begin
        if (!wbs_rx_cyc_i) begin
          last_rx_nxt = 1'b1;
          state_nxt   = wbs_tx_cyc_i ? GNT_TX : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign sel_tx  = (state == GNT_TX);
  assign sel_rx  = (state == GNT_RX);
  assign grant_o = state;
  assign resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;

  always_comb begin
    wbm_adr_o = '0;
    wbm_dat_o = '0;
    wbm_sel_o = '0;
    wbm_we_o  = 1'b0;
    wbm_cti_o = '0;
    wbm_bte_o = '0;
    cyc_mux   = 1'b0;
    stb_mux   = 1'b0;
    if (sel_tx) begin
      wbm_adr_o = wbs_tx_adr_i;
      wbm_dat_o = wbs_tx_dat_i;
      wbm_sel_o = wbs_tx_sel_i;
      wbm_we_o  = wbs_tx_we_i;
      wbm_cti_o = wbs_tx_cti_i;
      wbm_bte_o = wbs_tx_bte_i;
      cyc_mux   = wbs_tx_cyc_i;
      stb_mux   = wbs_tx_stb_i;
    end else if (sel_rx) begin
      wbm_adr_o = wbs_rx_adr_i;
      wbm_dat_o = wbs_rx_dat_i;
      wbm_sel_o = wbs_rx_sel_i;
      wbm_we_o  = wbs_rx_we_i;
      wbm_cti_o = wbs_rx_cti_i;
      wbm_bte_o = wbs_rx_bte_i;
      cyc_mux   = wbs_rx_cyc_i;
      stb_mux   = wbs_rx_stb_i;
    end
  end

`ifdef MYRIADRF_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign timeout_hit = !wb_rst && stb_mux && !resp &&
                       (wd_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk) begin
    if (wb_rst || (state_nxt != state) || !stb_mux || resp || timeout_hit)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign timeout_o = timeout_hit;
  // The abort cycle withdraws the request from memory while the owner sees err.
  assign wbm_cyc_o = cyc_mux & ~timeout_hit;
  assign wbm_stb_o = stb_mux & ~timeout_hit;

  assign wbs_tx_dat_o = wbm_dat_i;
  assign wbs_rx_dat_o = wbm_dat_i;
  assign wbs_tx_ack_o = sel_tx & wbm_ack_i;
  assign wbs_tx_err_o = sel_tx & (wbm_err_i | timeout_hit);
  assign wbs_tx_rty_o = sel_tx & wbm_rty_i;
  assign wbs_rx_ack_o = sel_rx & wbm_ack_i;
  assign wbs_rx_err_o = sel_rx & (wbm_err_i | timeout_hit);
  assign wbs_rx_rty_o = sel_rx & wbm_rty_i;

endmodule
